div_sequencer: RTL

//   Multi-cycle control stage wrapped around the combinational BITS-wide unsigned divider.

---
 rtl/div_sequencer_pkg.sv | 13 +
 rtl/div_sign_fix.sv | 14 +
 rtl/div_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider sequencer: FSM state encoding and default sizes.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_BITS   = 32;
    localparam int DEFAULT_SETTLE = 2;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module div_sign_fix
    import div_sequencer_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            neg,
    input  logic [BITS-1:0] value,
    output logic [BITS-1:0] result
);

    assign result = neg ? -value : value;

endmodule

// File: rtl/div_sequencer.sv
// Multicycle control stage around a combinational unsigned divider, with signed support.
// Optional macro DIV_ZERO_TRAP_EN adds a zero-divisor short path and the div_by_zero pulse.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int BITS          = DEFAULT_BITS,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_op,
    input  logic [BITS-1:0]   dividend,
    input  logic [BITS-1:0]   divisor,
    output logic [BITS-1:0]   div_num,
    output logic [BITS-1:0]   div_den,
    input  logic [2*BITS-1:0] div_result,
    output logic [BITS-1:0]   hi,
    output logic [BITS-1:0]   lo,
    output logic              busy,
    output logic              done
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic              div_by_zero
`endif
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BITS-1:0]   q_raw;
    logic [BITS-1:0]   r_raw;
    logic              neg_q;
    logic              neg_r;
    logic [BITS-1:0]   num_mag;
    logic [BITS-1:0]   den_mag;
    logic [BITS-1:0]   q_fix;
    logic [BITS-1:0]   r_fix;
    logic              num_neg;
    logic              den_neg;
`ifdef DIV_ZERO_TRAP_EN
    logic              dz_pending;
`endif

    assign num_neg = signed_op & dividend[BITS-1];
    assign den_neg = signed_op & divisor[BITS-1];

    div_sign_fix #(.BITS(BITS)) u_num_fix (.neg(num_neg), .value(dividend), .result(num_mag));
    div_sign_fix #(.BITS(BITS)) u_den_fix (.neg(den_neg), .value(divisor),  .result(den_mag));
    div_sign_fix #(.BITS(BITS)) u_q_fix   (.neg(neg_q),   .value(q_raw),    .result(q_fix));
    div_sign_fix #(.BITS(BITS)) u_r_fix   (.neg(neg_r),   .value(r_raw),    .result(r_fix));

    // Operands stay registered on div_num/div_den while WAIT lets the divider settle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            q_raw   <= '0;
            r_raw   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div_num <= '0;
            div_den <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            dz_pending  <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div_by_zero <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_num <= num_mag;
                        div_den <= den_mag;
                        neg_q   <= num_neg ^ den_neg;
                        neg_r   <= num_neg;
                        busy    <= 1'b1;
                        cnt     <= '0;
`ifdef DIV_ZERO_TRAP_EN
                        // Zero divisor bypasses the divider: raw dividend to HI, all ones to LO.
                        if (den_mag == '0) begin
                            r_raw      <= dividend;
                            q_raw      <= '1;
                            neg_q      <= 1'b0;
                            neg_r      <= 1'b0;
                            dz_pending <= 1'b1;
                            state      <= S_FIX;
                        end else begin
                            dz_pending <= 1'b0;
                            state      <= S_WAIT;
                        end
`else
                        state <= S_WAIT;
`endif
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        q_raw <= div_result[2*BITS-1:BITS];
                        r_raw <= div_result[BITS-1:0];
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo    <= q_fix;
                    hi    <= r_fix;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
`ifdef DIV_ZERO_TRAP_EN
                    div_by_zero <= dz_pending;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
